// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: coalescing posted write buffer in front of a word RAM. Optional stats via WBUF_STATS_EN.
// Latency: loads return the same cycle (buffer forward or RAM); stores are visible to reads from the next cycle.
// Backpressure: none; a full buffer force-drains its head so stores are never dropped and the core never stalls.
module dmem_wbuf_responder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ALU_result,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  input  logic                     mem_read,
  output logic [31:0]              ReadData,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_full
`ifdef WBUF_STATS_EN
  ,
  output logic [15:0]              fwd_hits,
  output logic [15:0]              coalesce_hits
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_idx [DEPTH];
  logic [31:0]       r_dat [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_ram [2**ADDR_W];

  logic [ADDR_W-1:0] w_idx;
  logic              w_any_hit;
  logic [PW-1:0]     w_hit_pos;
  logic              w_full;
  logic              w_coal;
  logic              w_enq;
  logic              w_drain;
  logic [31:0]       w_drain_dat;
  logic              w_unused;

  assign w_idx    = ALU_result[ADDR_W+1:2];
  assign w_unused = ^{ALU_result[31:ADDR_W+2], ALU_result[1:0]};

  // Coalescing guarantees at most one valid entry per word index.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_idx[i] == w_idx)) begin
        w_any_hit = 1'b1;
        w_hit_pos = PW'(i);
      end
    end
  end

  assign w_full  = (r_count == FULL_CNT);
  assign w_coal  = MemWrite && w_any_hit;
  assign w_enq   = MemWrite && !w_any_hit;
  assign w_drain = (r_count != '0) && (!mem_read || (w_full && w_enq));

  // A store coalescing into the head as it drains must reach RAM with the new data.
  assign w_drain_dat = (w_coal && (w_hit_pos == r_head)) ? WriteData : r_dat[r_head];

  assign ReadData = w_any_hit ? r_dat[w_hit_pos] : r_ram[w_idx];
  assign wb_count = r_count;
  assign wb_full  = w_full;

  // When full, head == tail: the pop clears the slot first and the enqueue then refills it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_coal) begin
        r_dat[w_hit_pos] <= WriteData;
      end
      if (w_drain) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_idx[r_tail] <= w_idx;
        r_dat[r_tail] <= WriteData;
        r_tail        <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_drain);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_drain) begin
      r_ram[r_idx[r_head]] <= w_drain_dat;
    end
  end

`ifdef WBUF_STATS_EN
  logic [15:0] r_fwd_hits;
  logic [15:0] r_coal_hits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_hits  <= '0;
      r_coal_hits <= '0;
    end else begin
      if (mem_read && w_any_hit && (r_fwd_hits != 16'hFFFF)) begin
        r_fwd_hits <= r_fwd_hits + 16'd1;
      end
      if (w_coal && (r_coal_hits != 16'hFFFF)) begin
        r_coal_hits <= r_coal_hits + 16'd1;
      end
    end
  end

  assign fwd_hits      = r_fwd_hits;
  assign coalesce_hits = r_coal_hits;
`endif

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Bench for dmem_wbuf_responder (DEPTH=4, ADDR_W=8): directed vector table, reset corner, random run vs queue model.
module tb_dmem_wbuf_responder;

  logic        clk;
  logic        reset;
  logic [31:0] ALU_result;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        mem_read;
  logic [31:0] ReadData;
  logic [2:0]  wb_count;
  logic        wb_full;
`ifdef WBUF_STATS_EN
  logic [15:0] fwd_hits;
  logic [15:0] coalesce_hits;
`endif

  dmem_wbuf_responder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALU_result   (ALU_result),
    .WriteData    (WriteData),
    .MemWrite     (MemWrite),
    .mem_read     (mem_read),
    .ReadData     (ReadData),
    .wb_count     (wb_count),
`ifdef WBUF_STATS_EN
    .fwd_hits     (fwd_hits),
    .coalesce_hits(coalesce_hits),
`endif
    .wb_full      (wb_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending stores as an ordered list, plus the RAM image.
  typedef struct {
    logic [7:0]  idx;
    logic [31:0] dat;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_ram [256];

  logic [31:0] obs_rd, e_rd;
  logic [2:0]  obs_cnt, e_cnt;
  logic        obs_full, e_full;

  function automatic logic [31:0] m_read(input logic [7:0] idx);
    logic [31:0] v;
    v = m_ram[idx];
    foreach (q[i]) if (q[i].idx == idx) v = q[i].dat;
    return v;
  endfunction

  task automatic m_step(input logic rst, input logic we, input logic rd,
                        input logic [7:0] idx, input logic [31:0] dat);
    int   hit;
    logic full, drain;
    ent_t e;
    if (rst) begin
      q.delete();
      return;
    end
    hit = -1;
    foreach (q[i]) if (q[i].idx == idx) hit = i;
    full  = (q.size() == 4);
    drain = (q.size() > 0) && (!rd || (full && we && hit < 0));
    if (we && hit >= 0) q[hit].dat = dat;
    if (drain) begin
      m_ram[q[0].idx] = q[0].dat;
      void'(q.pop_front());
    end
    if (we && hit < 0) begin
      e.idx = idx;
      e.dat = dat;
      q.push_back(e);
    end
  endtask

  // One clock: drive, sample outputs and model at the falling edge, then advance the model.
  task automatic step(input logic rst, input logic we, input logic rd,
                      input logic [31:0] addr, input logic [31:0] data);
    reset = rst; MemWrite = we; mem_read = rd; ALU_result = addr; WriteData = data;
    @(negedge clk);
    obs_rd   = ReadData;
    obs_cnt  = wb_count;
    obs_full = wb_full;
    e_rd     = m_read(addr[9:2]);
    e_cnt    = 3'(q.size());
    e_full   = (q.size() == 4);
    m_step(rst, we, rd, addr[9:2], data);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  cnt;
    logic        full;
    logic        chk_rd;
    logic [31:0] rdat;
  } vec_t;
  vec_t tv[20];

  initial begin
    // Expected outputs are the pre-edge values seen while the row's inputs are applied.
    tv[0]  = '{1'b0, 1'b1, 32'h00, 32'h0,        3'd0, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b1, 32'h10, 32'h0,        3'd1, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[3]  = '{1'b0, 1'b0, 32'h10, 32'h0,        3'd1, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[4]  = '{1'b0, 1'b1, 32'h10, 32'h0,        3'd0, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[5]  = '{1'b1, 1'b1, 32'h20, 32'h1,        3'd0, 1'b0, 1'b0, 32'h0};
    tv[6]  = '{1'b1, 1'b1, 32'h20, 32'h2,        3'd1, 1'b0, 1'b1, 32'h1};
    tv[7]  = '{1'b0, 1'b1, 32'h20, 32'h0,        3'd1, 1'b0, 1'b1, 32'h2};
    tv[8]  = '{1'b0, 1'b0, 32'h20, 32'h0,        3'd1, 1'b0, 1'b1, 32'h2};
    tv[9]  = '{1'b0, 1'b1, 32'h20, 32'h0,        3'd0, 1'b0, 1'b1, 32'h2};
    tv[10] = '{1'b1, 1'b1, 32'h00, 32'hA0,       3'd0, 1'b0, 1'b0, 32'h0};
    tv[11] = '{1'b1, 1'b1, 32'h04, 32'hA1,       3'd1, 1'b0, 1'b0, 32'h0};
    tv[12] = '{1'b1, 1'b1, 32'h08, 32'hA2,       3'd2, 1'b0, 1'b0, 32'h0};
    tv[13] = '{1'b1, 1'b1, 32'h0C, 32'hA3,       3'd3, 1'b0, 1'b0, 32'h0};
    tv[14] = '{1'b1, 1'b1, 32'h30, 32'hA4,       3'd4, 1'b1, 1'b0, 32'h0};
    tv[15] = '{1'b0, 1'b1, 32'h00, 32'h0,        3'd4, 1'b1, 1'b1, 32'hA0};
    tv[16] = '{1'b0, 1'b1, 32'h04, 32'h0,        3'd4, 1'b1, 1'b1, 32'hA1};
    tv[17] = '{1'b0, 1'b1, 32'h08, 32'h0,        3'd4, 1'b1, 1'b1, 32'hA2};
    tv[18] = '{1'b0, 1'b1, 32'h0C, 32'h0,        3'd4, 1'b1, 1'b1, 32'hA3};
    tv[19] = '{1'b0, 1'b1, 32'h30, 32'h0,        3'd4, 1'b1, 1'b1, 32'hA4};

    reset = 1'b1; MemWrite = 1'b0; mem_read = 1'b0; ALU_result = '0; WriteData = '0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int r = 0; r < 20; r++) begin
      step(1'b0, tv[r].we, tv[r].rd, tv[r].addr, tv[r].wdata);
      chk($sformatf("vec%0d_cnt", r), 32'(obs_cnt), 32'(tv[r].cnt));
      chk($sformatf("vec%0d_full", r), 32'(obs_full), 32'(tv[r].full));
      if (tv[r].chk_rd) chk($sformatf("vec%0d_rdata", r), obs_rd, tv[r].rdat);
    end

    // Reset with stores pending: buffered data is discarded, older RAM contents survive.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h40, 32'h11);
    chk("drain_empty_cnt", 32'(obs_cnt), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h44, 32'h22);
    step(1'b0, 1'b1, 1'b0, 32'h48, 32'h33);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h40, 32'h99);
    chk("pre_fill_cnt", 32'(obs_cnt), 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h44, 32'h98);
    step(1'b0, 1'b1, 1'b1, 32'h48, 32'h97);
    step(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    chk("pre_reset_cnt", 32'(obs_cnt), 32'd3);
    chk("pre_reset_fwd", obs_rd, 32'h99);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    chk("post_reset_cnt", 32'(obs_cnt), 32'd0);
    chk("post_reset_full", 32'(obs_full), 32'd0);
    chk("post_reset_rd40", obs_rd, 32'h11);
    step(1'b0, 1'b0, 1'b1, 32'h44, 32'h0);
    chk("post_reset_rd44", obs_rd, 32'h22);
    step(1'b0, 1'b0, 1'b1, 32'h48, 32'h0);
    chk("post_reset_rd48", obs_rd, 32'h33);

`ifdef WBUF_STATS_EN
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h100, 32'h6);
    @(negedge clk);
    chk("stats_fwd", 32'(fwd_hits), 32'd2);
    chk("stats_coal", 32'(coalesce_hits), 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("stats_fwd_reset", 32'(fwd_hits), 32'd0);
    chk("stats_coal_reset", 32'(coalesce_hits), 32'd0);
    @(posedge clk);
    #1;
`endif

    // Give every RAM word a known value, then run random traffic against the model.
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b0, 32'(i) << 2, $urandom);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [7:0]  idx;
      logic        we, rd, rst;
      idx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      a    = $urandom;
      a[9:2] = idx;
      we   = 1'($urandom_range(0, 1));
      rd   = ($urandom_range(0, 9) < 8);
      rst  = ($urandom_range(0, 199) == 0);
      step(rst, we, rd, a, $urandom);
      chk("rand_rdata", obs_rd, e_rd);
      chk("rand_cnt", 32'(obs_cnt), 32'(e_cnt));
      chk("rand_full", 32'(obs_full), 32'(e_full));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
